// File: rtl/epoch_spi_host.sv
// SPI mode-0 master that writes or reads the RTC's 64-bit epoch in one framed transfer:
// a command byte followed by eight data bytes, MSB first.
module epoch_spi_host #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned BYTE_GAP = 8,
  parameter logic [7:0]  WRCMD    = 8'h01,
  parameter logic [7:0]  RDCMD    = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [63:0] i_time,
  output logic [63:0] o_time,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss
);

  localparam int unsigned CNT_MAX   = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned FRAME_W   = 72;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((BYTE_GAP == 0) ? 0 : BYTE_GAP - 1);
  localparam logic [4:0] EDGES_PER_BYTE = 5'd16;
  localparam logic [3:0] LAST_BYTE      = 4'd8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [4:0]         r_edge, w_edge;
  logic [3:0]         r_byte, w_byte;
  logic               r_sclk, w_sclk;
  logic               r_ss, w_ss;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_rw, w_rw;
  logic [FRAME_W-1:0] r_tx, w_tx;
  logic [63:0]        r_rx, w_rx;
  logic [63:0]        r_time, w_time;
  logic               w_tick;
  logic               w_rise;

  assign o_time = r_time;
  assign busy   = r_busy;
  assign done   = r_done;
  assign sclk   = r_sclk;
  assign ss     = r_ss;
  assign mosi   = r_tx[FRAME_W-1];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_edge  <= '0;
      r_byte  <= '0;
      r_sclk  <= 1'b0;
      r_ss    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rw    <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_time  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_edge  <= w_edge;
      r_byte  <= w_byte;
      r_sclk  <= w_sclk;
      r_ss    <= w_ss;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_rw    <= w_rw;
      r_tx    <= w_tx;
      r_rx    <= w_rx;
      r_time  <= w_time;
    end
  end

  // Next-state and next-output logic; a rising sclk edge is requested via w_rise
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_edge  = r_edge;
    w_byte  = r_byte;
    w_sclk  = r_sclk;
    w_ss    = r_ss;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_rw    = r_rw;
    w_tx    = r_tx;
    w_rx    = r_rx;
    w_time  = r_time;
    w_rise  = 1'b0;
    w_tick  = (r_cnt == DIV_LAST);

    case (r_state)
      IDLE: begin
        // The done cycle is also IDLE; a start there must be dropped
        if (start && !r_done) begin
          w_state = SETUP;
          w_ss    = 1'b0;
          w_busy  = 1'b1;
          w_rw    = rw;
          w_tx    = rw ? {RDCMD, 64'h0} : {WRCMD, i_time};
          w_cnt   = '0;
          w_edge  = '0;
          w_byte  = '0;
        end
      end
      SETUP: begin
        if (w_tick) begin
          w_cnt  = '0;
          w_rise = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (w_tick) begin
          w_cnt = '0;
          if (r_edge == EDGES_PER_BYTE) begin
            if (r_byte == LAST_BYTE) begin
              w_state = HOLD;
            end else begin
              w_byte = r_byte + 4'd1;
              if (BYTE_GAP == 0) begin
                w_rise = 1'b1;
              end else begin
                w_state = GAP;
              end
            end
          end else if (r_sclk) begin
            w_sclk = 1'b0;
            w_tx   = {r_tx[FRAME_W-2:0], 1'b0};
            w_edge = r_edge + 5'd1;
          end else begin
            w_rise = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt  = '0;
          w_rise = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (w_tick) begin
          w_state = IDLE;
          w_cnt   = '0;
          w_ss    = 1'b1;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          if (r_rw) begin
            w_time = r_rx;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase

    // Rising edge: sample miso; the first 8 samples fall off the top of the 64-bit register
    if (w_rise) begin
      w_state = SHIFT;
      w_sclk  = 1'b1;
      w_rx    = {r_rx[62:0], miso};
      w_edge  = ((r_state == SHIFT) && (r_edge != EDGES_PER_BYTE)) ? (r_edge + 5'd1) : 5'd1;
    end
  end

endmodule
